// File: rtl/pattern_tx_serial_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package pattern_tx_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} tx_state_e;

    localparam int DEFAULT_PAT_W = 4;
    localparam logic [DEFAULT_PAT_W-1:0] DEFAULT_PATTERN = 4'b1101;
    localparam int IDX_W = $clog2(DEFAULT_PAT_W);

    // Bit-index width for an arbitrary pattern length, never narrower than one bit.
    function automatic int idx_width(input int pat_w);
        return (pat_w > 2) ? $clog2(pat_w) : 1;
    endfunction

endpackage

// File: rtl/pattern_tx_serial_if.sv
// Request/line bundle between a pattern source controller and the transmitter.
interface pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             start;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap;
    logic             out;
    logic             valid;
    logic             last;
    logic             busy;
    logic             done;

    modport master (
        output load, pat_in, start, rep_cnt, gap,
        input  out, valid, last, busy, done
    );

    modport slave (
        input  load, pat_in, start, rep_cnt, gap,
        output out, valid, last, busy, done
    );
endinterface

// File: rtl/pattern_tx_serial_counter.sv
// Loadable down counter with zero flag; a decrement at zero holds the count.
module tx_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
endmodule

// File: rtl/pattern_tx_serial.sv
// Shifts a programmable pattern out MSB-first for N repetitions, optionally
// separated by zero-bit gaps, with a last marker on each instance's LSB.
module pattern_tx_serial
    import pattern_tx_pkg::*;
#(
    parameter int               PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input logic         clk,
    input logic         rst,
    pattern_tx_if.slave bus
);
    localparam int            IW      = idx_width(PAT_W);
    localparam logic [IW-1:0] IDX_TOP = IW'(PAT_W - 1);

    tx_state_e        state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic out_q, out_d, valid_q, valid_d, last_q, last_d;
    logic busy_q, busy_d, done_q, done_d;

    logic [IW-1:0]    idx_count, idx_next;
    logic [GAP_W-1:0] gap_count;
    logic [CNT_W-1:0] reps_count;
    logic idx_zero, gap_zero, reps_zero;
    logic idx_load, idx_dec, gap_load, gap_dec, reps_dec;
    logic start_go, send_end, last_rep, next_inst, gap_exit;

    tx_down_counter #(.W(IW)) u_idx (
        .clk(clk), .rst(rst), .load(idx_load), .load_val(IDX_TOP),
        .dec(idx_dec), .count(idx_count), .zero(idx_zero)
    );

    tx_down_counter #(.W(GAP_W)) u_gap (
        .clk(clk), .rst(rst), .load(gap_load), .load_val(gap_len_q),
        .dec(gap_dec), .count(gap_count), .zero(gap_zero)
    );

    tx_down_counter #(.W(CNT_W)) u_reps (
        .clk(clk), .rst(rst), .load(start_go), .load_val(bus.rep_cnt),
        .dec(reps_dec), .count(reps_count), .zero(reps_zero)
    );

    always_comb begin
        start_go  = (state_q == IDLE) && bus.start && (bus.rep_cnt != '0);
        send_end  = (state_q == SEND) && idx_zero;
        last_rep  = (reps_count == CNT_W'(1));
        next_inst = send_end && !last_rep;
        gap_exit  = (state_q == GAP) && (gap_zero || (gap_count == GAP_W'(1)));

        idx_load  = start_go || (next_inst && (gap_len_q == '0)) || gap_exit;
        idx_dec   = (state_q == SEND) && !idx_zero;
        gap_load  = next_inst && (gap_len_q != '0);
        gap_dec   = (state_q == GAP);
        // Remaining reps bottoms out at one; the FSM leaves SEND on that value.
        reps_dec  = next_inst && !reps_zero;

        idx_next  = idx_load ? IDX_TOP : (idx_dec ? idx_count - IW'(1) : idx_count);

        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = (bus.rep_cnt != '0) ? SEND : DONE;
            SEND: if (idx_zero) begin
                if (last_rep)
                    state_d = DONE;
                else if (gap_len_q == '0)
                    state_d = SEND;
                else
                    state_d = GAP;
            end
            GAP:  if (gap_exit) state_d = SEND;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pat_d     = ((state_q == IDLE) && bus.load) ? bus.pat_in : pat_q;
        gap_len_d = start_go ? bus.gap : gap_len_q;

        // Outputs are precomputed from next state so they leave a flop cleanly.
        out_d   = (state_d == SEND) && pat_d[idx_next];
        valid_d = (state_d == SEND) || (state_d == GAP);
        busy_d  = valid_d;
        last_d  = (state_d == SEND) && (idx_next == '0);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pat_q     <= PATTERN;
            gap_len_q <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            gap_len_q <= gap_len_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.last  = last_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
